// File: rtl/my_mv_filter_gate_v2.sv
// Boxcar moving-average filter with trigger decimation and runtime window size.
// Ports: clk, n_rst (async low); trig/din sample in; div_factor, log2_win, clear
// control; dout/dout_valid/filled/busy out. Optional MVF_MONITOR_EN adds
// mon_sum/mon_last.
module my_mv_filter_gate_v2 #(
    parameter int DW           = 32,
    parameter int LOG2_WIN_MAX = 13,
    parameter int DIV_W        = 8,
    parameter int ACC_W        = DW + LOG2_WIN_MAX
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             trig,
    input  logic [DW-1:0]    din,
    input  logic [DIV_W-1:0] div_factor,
    input  logic [3:0]       log2_win,
    input  logic             clear,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic             filled,
    output logic             busy
`ifdef MVF_MONITOR_EN
    ,
    output logic [ACC_W-1:0] mon_sum,
    output logic [DW-1:0]    mon_last
`endif
);

    localparam int AW    = LOG2_WIN_MAX;
    localparam int DEPTH = 1 << AW;
    localparam int EXT   = ACC_W - DW;
    localparam logic [3:0]    LW_MAX    = 4'(LOG2_WIN_MAX);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]           clr_addr;
    logic [3:0]              lw, lw_in;
    logic                    lw_loaded;
    logic                    restart;
    logic [AW-1:0]           mask;
    logic [AW-1:0]           wr_idx, wr_idx_inc, rd_addr;
    logic [DIV_W-1:0]        decim_cnt;
    logic                    decim_hit, accept;
    logic                    s1_valid;
    logic [DW-1:0]           s1_din;
    logic                    fwd;
    logic [DW-1:0]           fwd_data;
    logic [DW-1:0]           ram_q, oldest;
    logic signed [ACC_W-1:0] sum, sum_new;
    logic                    ram_we;
    logic [AW-1:0]           ram_wa;
    logic [DW-1:0]           ram_wd;
    logic [DW-1:0]           mem [DEPTH];

    // lw is loaded on the first cycle after reset without counting as a change.
    assign lw_in   = (log2_win > LW_MAX) ? LW_MAX : log2_win;
    assign restart = clear || (lw_loaded && (lw_in != lw));
    assign mask    = ~({AW{1'b1}} << lw);

    assign wr_idx_inc = (wr_idx + AW'(1)) & mask;
    // The sample in stage 1 advances wr_idx at this edge, so look one ahead.
    assign rd_addr    = s1_valid ? wr_idx_inc : wr_idx;

    assign decim_hit = (div_factor <= DIV_W'(1)) ||
                       (decim_cnt == div_factor - DIV_W'(1));
    assign accept    = (state == S_RUN) && trig && !restart && decim_hit;

    // With a one-entry window the read and the pending write hit one address.
    assign oldest  = fwd ? fwd_data : ram_q;
    assign sum_new = sum
                   - {{EXT{oldest[DW-1]}}, oldest}
                   + {{EXT{s1_din[DW-1]}}, s1_din};

    always_comb begin
        state_nxt = state;
        busy      = (state == S_CLEAR);
        case (state)
            S_CLEAR: if (clr_addr == ADDR_LAST) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
        if (restart) state_nxt = S_CLEAR;
    end

    always_comb begin
        ram_we = 1'b0;
        ram_wa = wr_idx;
        ram_wd = s1_din;
        if (state == S_CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_addr;
            ram_wd = '0;
        end else if (s1_valid && !restart) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            lw         <= '0;
            lw_loaded  <= 1'b0;
            decim_cnt  <= '0;
            s1_valid   <= 1'b0;
            s1_din     <= '0;
            fwd        <= 1'b0;
            fwd_data   <= '0;
            wr_idx     <= '0;
            sum        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            filled     <= 1'b0;
        end else begin
            state      <= state_nxt;
            lw         <= lw_in;
            lw_loaded  <= 1'b1;
            dout_valid <= 1'b0;
            if (restart) begin
                clr_addr  <= '0;
                decim_cnt <= '0;
                s1_valid  <= 1'b0;
                fwd       <= 1'b0;
                wr_idx    <= '0;
                sum       <= '0;
                dout      <= '0;
                filled    <= 1'b0;
            end else begin
                clr_addr <= (state == S_CLEAR) ? clr_addr + AW'(1) : '0;
                if (state == S_CLEAR)
                    decim_cnt <= '0;
                else if (trig)
                    decim_cnt <= decim_hit ? '0 : decim_cnt + DIV_W'(1);
                s1_valid <= accept;
                if (accept) s1_din <= din;
                fwd      <= accept && s1_valid && (rd_addr == wr_idx);
                fwd_data <= s1_din;
                if (s1_valid) begin
                    sum        <= sum_new;
                    wr_idx     <= wr_idx_inc;
                    dout       <= DW'(sum_new >>> lw);
                    dout_valid <= 1'b1;
                    filled     <= filled | (wr_idx == mask);
                end
            end
        end
    end

`ifdef MVF_MONITOR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mon_sum  <= '0;
            mon_last <= '0;
        end else if (s1_valid && !restart) begin
            mon_sum  <= sum_new;
            mon_last <= s1_din;
        end
    end
`endif

endmodule

// File: tb/tb_my_mv_filter_gate_v2.sv
// Self-checking bench for my_mv_filter_gate_v2 (LOG2_WIN_MAX=4).
// Directed spec scenarios plus a randomized run against a window-sum model.
module tb_my_mv_filter_gate_v2;

    localparam int DW    = 32;
    localparam int LWM   = 4;
    localparam int DIV_W = 8;
    localparam int ACC_W = DW + LWM;

    logic             clk        = 1'b0;
    logic             n_rst      = 1'b0;
    logic             trig       = 1'b0;
    logic             clear      = 1'b0;
    logic [DW-1:0]    din        = '0;
    logic [DIV_W-1:0] div_factor = 8'd1;
    logic [3:0]       log2_win   = 4'd2;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             filled;
    logic             busy;
`ifdef MVF_MONITOR_EN
    logic [ACC_W-1:0] mon_sum;
    logic [DW-1:0]    mon_last;
`endif

    my_mv_filter_gate_v2 #(
        .DW(DW), .LOG2_WIN_MAX(LWM), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .trig(trig), .din(din),
        .div_factor(div_factor), .log2_win(log2_win), .clear(clear),
        .dout(dout), .dout_valid(dout_valid), .filled(filled),
        .busy(busy)
`ifdef MVF_MONITOR_EN
        , .mon_sum(mon_sum), .mon_last(mon_last)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference model: explicit sample history, window sum, floor division.
    typedef struct {
        int     due;
        longint d;
        bit     f;
    } item_t;

    item_t  pend[$];
    longint hist[$];
    int     m_busy   = 16;
    bit     m_lwv    = 0;
    int     m_lw     = 0;
    int     m_cnt    = 0;
    int     e_cnt    = 0;
    bit     e_vld    = 0;
    bit     e_filled = 0;
    longint e_dout   = 0;

    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q -= 1;
        return q;
    endfunction

    task automatic model_reset();
        m_busy = 16; m_lwv = 0; m_lw = 0; m_cnt = 0;
        hist.delete(); pend.delete();
        e_vld = 0; e_dout = 0; e_filled = 0;
    endtask

    task automatic model_step();
        int     lwc;
        int     w;
        bit     rs;
        longint s;
        item_t  it;
        if (!n_rst) begin
            model_reset();
            return;
        end
        e_cnt++;
        lwc = (int'(log2_win) > LWM) ? LWM : int'(log2_win);
        rs  = clear || (m_lwv && lwc != m_lw);
        m_lwv = 1;
        m_lw  = lwc;
        if (rs) begin
            m_busy = 16; m_cnt = 0;
            hist.delete(); pend.delete();
            e_vld = 0; e_dout = 0; e_filled = 0;
            return;
        end
        e_vld = 0;
        if (pend.size() != 0 && pend[0].due == e_cnt) begin
            it = pend.pop_front();
            e_vld = 1; e_dout = it.d; e_filled = it.f;
        end
        if (m_busy != 0) begin
            m_busy--;
            m_cnt = 0;
        end else if (trig) begin
            if (div_factor <= 1 || m_cnt == int'(div_factor) - 1) begin
                m_cnt = 0;
                hist.push_back(longint'($signed(din)));
                if (hist.size() > 16) void'(hist.pop_front());
                w = 1 << m_lw;
                s = 0;
                for (int i = 0; i < w && i < hist.size(); i++)
                    s += hist[hist.size() - 1 - i];
                it.due = e_cnt + 1;
                it.d   = floor_div(s, longint'(w));
                it.f   = (hist.size() >= w);
                pend.push_back(it);
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge n_rst);
        model_step();
    end

    longint cap_d[$];
    bit     cap_f[$];
    int     cap_e[$];

    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        if (n_rst) begin
            chk("busy", busy, m_busy != 0);
            chk("dout_valid", dout_valid, e_vld);
            chk("dout", $signed(dout), e_dout);
            chk("filled", filled, e_filled);
        end
        if (dout_valid) begin
            cap_d.push_back(longint'($signed(dout)));
            cap_f.push_back(filled);
            cap_e.push_back(cyc);
        end
    end

    task automatic cap_flush();
        cap_d.delete(); cap_f.delete(); cap_e.delete();
    endtask

    task automatic measure_busy(output int n);
        n = busy ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (!busy) break;
            n++;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        trig = 1'b1;
        din  = d;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        trig = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_lw(input logic [3:0] v);
        int n;
        @(negedge clk);
        log2_win = v;
        @(negedge clk);
        measure_busy(n);
        chk("busy_len_lw", n, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    longint exp_ma[5] = '{25, 50, 75, 100, 100};

    initial begin
        int n;
        int t4, t8, t0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_filled", filled, 0);

        cap_flush();
        trig  = 1'b1;
        din   = 32'd999;
        n_rst = 1'b1;
        measure_busy(n);
        chk("busy_len_reset", n, 16);
        idle(3);
        chk("trig_in_busy", cap_d.size(), 0);

        cap_flush();
        for (int i = 0; i < 5; i++) send(32'd100);
        idle(4);
        chk("ma_count", cap_d.size(), 5);
        for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
            chk("ma_dout", cap_d[i], exp_ma[i]);
            chk("ma_filled", cap_f[i], (i >= 3) ? 1 : 0);
        end

        div_factor = 8'd4;
        set_lw(4'd0);
        cap_flush();
        t4 = 0; t8 = 0;
        for (int i = 1; i <= 8; i++) begin
            send(32'd40);
            if (i == 4) t4 = cyc;
            if (i == 8) t8 = cyc;
        end
        idle(4);
        chk("decim_count", cap_d.size(), 2);
        if (cap_d.size() >= 2) begin
            chk("decim_t1", cap_e[0], t4 + 2);
            chk("decim_t2", cap_e[1], t8 + 2);
            chk("decim_d1", cap_d[0], 40);
            chk("decim_d2", cap_d[1], 40);
        end

        div_factor = 8'd1;
        set_lw(4'd1);
        cap_flush();
        send(-32'sd3);
        t0 = cyc;
        idle(4);
        chk("neg_count", cap_d.size(), 1);
        if (cap_d.size() >= 1) begin
            chk("neg_floor", cap_d[0], -2);
            chk("neg_lat", cap_e[0], t0 + 2);
        end

        set_lw(4'd0);
        cap_flush();
        send(32'd5);
        t0 = cyc;
        send(32'd7);
        send(32'd9);
        idle(4);
        chk("fwd_count", cap_d.size(), 3);
        for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
            chk("fwd_dout", cap_d[i], 5 + 2 * i);
            chk("fwd_time", cap_e[i], t0 + 2 + i);
        end

        set_lw(4'd2);
        for (int i = 0; i < 6; i++) send($urandom_range(1, 1000));
        idle(3);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_dout", dout, 0);
        chk("clr_filled", filled, 0);
        measure_busy(n);
        chk("busy_len_clear", n, 16);
        for (int i = 0; i < 6; i++) send($urandom_range(1, 1000));
        idle(3);
        @(negedge clk);
        log2_win = 4'd3;
        @(negedge clk);
        chk("lwchg_dout", dout, 0);
        chk("lwchg_filled", filled, 0);
        measure_busy(n);
        chk("busy_len_lwchg", n, 16);
        cap_flush();
        send(32'd80);
        idle(4);
        chk("lw3_count", cap_d.size(), 1);
        if (cap_d.size() >= 1) chk("lw3_dout", cap_d[0], 10);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            trig  = ($urandom_range(0, 99) < 60);
            din   = $urandom();
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0)
                log2_win = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0)
                div_factor = 8'($urandom_range(0, 5));
            if (i == 700) begin
                n_rst = 1'b0;
                #1;
                chk("mid_rst_busy", busy, 1);
                chk("mid_rst_dout", dout, 0);
                chk("mid_rst_valid", dout_valid, 0);
                chk("mid_rst_filled", filled, 0);
                repeat (3) @(negedge clk);
                n_rst = 1'b1;
            end
        end
        clear = 1'b0;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
